// File: rtl/axi_burst_mem_slave.sv
// AXI4-style burst memory slave: independent write (AW/W/B) and read (AR/R) engines over a
// shared word memory, with FIXED/INCR/WRAP bursts, byte strobes and SLVERR reporting.
module axi_burst_mem_slave #(
   parameter int unsigned       DATA_BYTES = 4,
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       MEM_DEPTH  = 64,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic                    aclk,
   input  logic                    reset,
   // write address
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_W-1:0]       awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   // write data
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_BYTES*8-1:0] wdata,
   input  logic [DATA_BYTES-1:0]   wstrb,
   input  logic                    wlast,
   // write response
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   // read address
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_W-1:0]       araddr,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   // read data
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_BYTES*8-1:0] rdata,
   output logic [1:0]              rresp,
   output logic                    rlast
);

   localparam int unsigned       DW     = DATA_BYTES * 8;
   localparam int unsigned       LaneW  = $clog2(DATA_BYTES);
   localparam int unsigned       IdxW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_W:0]   MemEnd = {1'b0, BASE_ADDR} + (ADDR_W+1)'(MEM_DEPTH * DATA_BYTES);
   localparam logic [1:0]        RespOkay   = 2'b00;
   localparam logic [1:0]        RespSlvErr = 2'b10;

   function automatic logic [ADDR_W-1:0] f_beat_bytes(input logic [2:0] size);
      return ADDR_W'(1) << size;
   endfunction

   function automatic logic [ADDR_W-1:0] f_align(input logic [ADDR_W-1:0] addr,
                                                 input logic [2:0]        size);
      return addr & ~(f_beat_bytes(size) - ADDR_W'(1));
   endfunction

   // WRAP boundary is recomputed from the current address; it is invariant for legal wraps.
   function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [2:0]        size,
                                                     input logic [7:0]        len,
                                                     input logic [1:0]        burst);
      logic [ADDR_W-1:0] bytes, span, wbase, incr, res;
      bytes = f_beat_bytes(size);
      span  = bytes * (ADDR_W'(len) + ADDR_W'(1));
      wbase = addr & ~(span - ADDR_W'(1));
      incr  = addr + bytes;
      case (burst)
         2'b00:   res = addr;
         2'b10:   res = (incr == wbase + span) ? wbase : incr;
         default: res = incr;
      endcase
      return res;
   endfunction

   function automatic logic f_desc_bad(input logic [2:0] size,
                                       input logic [7:0] len,
                                       input logic [1:0] burst);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (burst == 2'b11) || (32'(size) > LaneW) || ((burst == 2'b10) && !wrap_len_ok);
   endfunction

   function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
      return ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < MemEnd);
   endfunction

   function automatic logic [IdxW-1:0] f_index(input logic [ADDR_W-1:0] addr);
      return IdxW'((addr - BASE_ADDR) >> LaneW);
   endfunction

   logic [DW-1:0] r_mem [MEM_DEPTH];

   // ---------------------------------------------------------------- write engine
   typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;

   wr_state_e         r_wstate, w_wstate_d;
   logic              r_awready, r_wready, r_bvalid;
   logic              w_awready_d, w_wready_d, w_bvalid_d;
   logic [1:0]        r_bresp, w_bresp_d;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_wlen, r_wbeat;
   logic [2:0]        r_wsize;
   logic [1:0]        r_wburst;
   logic              r_wbad, r_wover, r_werr;
   logic              w_aw_hs, w_w_hs, w_b_hs, w_wdesc_bad, w_wbeat_err, w_wr_en;

   assign w_aw_hs     = awvalid & r_awready;
   assign w_w_hs      = wvalid & r_wready;
   assign w_b_hs      = r_bvalid & bready;
   assign w_wdesc_bad = f_desc_bad(awsize, awlen, awburst);
   // r_wover marks beats past awlen; they are consumed but never written
   assign w_wbeat_err = r_wbad | r_wover | !f_in_range(r_waddr) | (wlast != (r_wbeat == r_wlen));
   assign w_wr_en     = w_w_hs & !r_wbad & !r_wover & f_in_range(r_waddr);

   always_comb begin
      w_wstate_d = r_wstate;
      w_bresp_d  = r_bresp;
      unique case (r_wstate)
         WrIdle: if (w_aw_hs) w_wstate_d = WrData;
         WrData: begin
            if (w_w_hs && wlast) begin
               w_wstate_d = WrResp;
               w_bresp_d  = (r_werr | w_wbeat_err) ? RespSlvErr : RespOkay;
            end
         end
         WrResp: begin
            if (w_b_hs) begin
               w_wstate_d = WrIdle;
               w_bresp_d  = RespOkay;
            end
         end
         default: w_wstate_d = WrIdle;
      endcase
      w_awready_d = (w_wstate_d == WrIdle);
      w_wready_d  = (w_wstate_d == WrData);
      w_bvalid_d  = (w_wstate_d == WrResp);
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         r_wstate  <= WrIdle;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RespOkay;
      end else begin
         r_wstate  <= w_wstate_d;
         r_awready <= w_awready_d;
         r_wready  <= w_wready_d;
         r_bvalid  <= w_bvalid_d;
         r_bresp   <= w_bresp_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         r_waddr  <= '0;
         r_wlen   <= '0;
         r_wsize  <= '0;
         r_wburst <= '0;
         r_wbeat  <= '0;
         r_wbad   <= 1'b0;
         r_wover  <= 1'b0;
         r_werr   <= 1'b0;
      end else if (w_aw_hs) begin
         r_waddr  <= f_align(awaddr, awsize);
         r_wlen   <= awlen;
         r_wsize  <= awsize;
         r_wburst <= awburst;
         r_wbeat  <= '0;
         r_wbad   <= w_wdesc_bad;
         r_wover  <= 1'b0;
         r_werr   <= w_wdesc_bad;
      end else if (w_w_hs) begin
         r_waddr <= f_next_addr(r_waddr, r_wsize, r_wlen, r_wburst);
         r_wbeat <= r_wbeat + 8'd1;
         r_werr  <= r_werr | w_wbeat_err;
         if (r_wbeat == r_wlen) r_wover <= 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         for (int unsigned i = 0; i < MEM_DEPTH; i++) r_mem[IdxW'(i)] <= '0;
      end else if (w_wr_en) begin
         for (int unsigned b = 0; b < DATA_BYTES; b++) begin
            if (wstrb[b]) r_mem[f_index(r_waddr)][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   // ---------------------------------------------------------------- read engine
   typedef enum logic {RdIdle, RdData} rd_state_e;

   rd_state_e         r_rstate, w_rstate_d;
   logic              r_arready, r_rvalid, w_arready_d, w_rvalid_d;
   logic [DW-1:0]     r_rdata;
   logic [1:0]        r_rresp;
   logic              r_rlast;
   logic [ADDR_W-1:0] r_raddr, w_rload_addr;
   logic [7:0]        r_rlen, r_rbeat, w_rlen, w_rload_beat;
   logic [2:0]        r_rsize, w_rsize;
   logic [1:0]        r_rburst, w_rburst;
   logic              w_ar_hs, w_r_acc, w_rload, w_rload_err;

   assign w_ar_hs  = arvalid & r_arready;
   assign w_r_acc  = r_rvalid & rready;
   assign w_rload  = w_ar_hs | (w_r_acc & !r_rlast);
   assign w_rsize  = w_ar_hs ? arsize  : r_rsize;
   assign w_rlen   = w_ar_hs ? arlen   : r_rlen;
   assign w_rburst = w_ar_hs ? arburst : r_rburst;
   // next beat is fetched on the accepting edge so the stream has no bubble
   assign w_rload_addr = w_ar_hs ? f_align(araddr, arsize)
                                 : f_next_addr(r_raddr, r_rsize, r_rlen, r_rburst);
   assign w_rload_beat = w_ar_hs ? 8'd0 : r_rbeat + 8'd1;
   assign w_rload_err  = f_desc_bad(w_rsize, w_rlen, w_rburst) | !f_in_range(w_rload_addr);

   always_comb begin
      w_rstate_d = r_rstate;
      unique case (r_rstate)
         RdIdle:  if (w_ar_hs) w_rstate_d = RdData;
         RdData:  if (w_r_acc && r_rlast) w_rstate_d = RdIdle;
         default: w_rstate_d = RdIdle;
      endcase
      w_arready_d = (w_rstate_d == RdIdle);
      w_rvalid_d  = (w_rstate_d == RdData);
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         r_rstate  <= RdIdle;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
      end else begin
         r_rstate  <= w_rstate_d;
         r_arready <= w_arready_d;
         r_rvalid  <= w_rvalid_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         r_raddr  <= '0;
         r_rlen   <= '0;
         r_rsize  <= '0;
         r_rburst <= '0;
         r_rbeat  <= '0;
         r_rdata  <= '0;
         r_rresp  <= RespOkay;
         r_rlast  <= 1'b0;
      end else begin
         if (w_ar_hs) begin
            r_rlen   <= arlen;
            r_rsize  <= arsize;
            r_rburst <= arburst;
         end
         if (w_rload) begin
            r_raddr <= w_rload_addr;
            r_rbeat <= w_rload_beat;
            r_rdata <= w_rload_err ? '0 : r_mem[f_index(w_rload_addr)];
            r_rresp <= w_rload_err ? RespSlvErr : RespOkay;
            r_rlast <= (w_rload_beat == w_rlen);
         end else if (w_r_acc) begin
            r_rlast <= 1'b0;
         end
      end
   end

   assign awready = r_awready;
   assign wready  = r_wready;
   assign bvalid  = r_bvalid;
   assign bresp   = r_bresp;
   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rdata   = r_rdata;
   assign rresp   = r_rresp;
   assign rlast   = r_rlast;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: expected B/R results are queued as bursts are issued
// and compared by a negedge monitor as the slave returns them.
module tb_axi_burst_mem_slave;

   localparam logic [1:0] Fixed = 2'b00, Incr = 2'b01, Wrap = 2'b10, BadBurst = 2'b11;
   localparam logic [1:0] Okay = 2'b00, SlvErr = 2'b10;

   logic        aclk = 1'b0;
   logic        reset = 1'b1;
   logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  wstrb;
   logic        arvalid, arready, rvalid, rready, rlast;

   always #5 aclk = ~aclk;

   axi_burst_mem_slave #(
      .DATA_BYTES(4),
      .ADDR_W    (32),
      .MEM_DEPTH (64),
      .BASE_ADDR (32'h0)
   ) u_dut (
      .aclk   (aclk),
      .reset  (reset),
      .awvalid(awvalid),
      .awready(awready),
      .awaddr (awaddr),
      .awlen  (awlen),
      .awsize (awsize),
      .awburst(awburst),
      .wvalid (wvalid),
      .wready (wready),
      .wdata  (wdata),
      .wstrb  (wstrb),
      .wlast  (wlast),
      .bvalid (bvalid),
      .bready (bready),
      .bresp  (bresp),
      .arvalid(arvalid),
      .arready(arready),
      .araddr (araddr),
      .arlen  (arlen),
      .arsize (arsize),
      .arburst(arburst),
      .rvalid (rvalid),
      .rready (rready),
      .rdata  (rdata),
      .rresp  (rresp),
      .rlast  (rlast)
   );

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  r;
      logic        l;
   } rexp_t;

   rexp_t       rq[$];
   logic [1:0]  bq[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] wd[256];
   logic [3:0]  ws[256];
   logic [31:0] ed[256];
   logic [1:0]  er[256];
   logic        rr_pat[16];
   int          rr_len = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   // an unexpected beat is compared against an impossible response so it always counts as a miss
   always @(negedge aclk) begin
      if (!reset) begin
         if (rvalid && !rready && rq.size() != 0) check_eq("r_stall_data", rdata, rq[0].d);
         if (rvalid && rready) begin
            rexp_t e;
            e = (rq.size() != 0) ? rq.pop_front() : '{d: 32'hDEAD_BEEF, r: 2'b11, l: 1'b1};
            check_eq("rdata", rdata, e.d);
            check_eq("rresp", rresp, e.r);
            check_eq("rlast", rlast, e.l);
         end
         if (bvalid && bready) check_eq("bresp", bresp, (bq.size() != 0) ? bq.pop_front() : 2'b11);
      end
   end

   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int last_beat,
                           input logic [1:0] exp_bresp);
      int cnt;
      bq.push_back(exp_bresp);
      awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      cnt = 0;
      while (!awready && cnt < 50) begin @(posedge aclk); #1; cnt++; end
      check_eq("aw_wait", cnt < 50, 1);
      @(posedge aclk); #1;
      awvalid = 1'b0;
      for (int i = 0; i <= last_beat; i++) begin
         wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_beat); wvalid = 1'b1;
         cnt = 0;
         while (!wready && cnt < 50) begin @(posedge aclk); #1; cnt++; end
         @(posedge aclk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      cnt = 0;
      while (!bvalid && cnt < 50) begin @(posedge aclk); #1; cnt++; end
      check_eq("b_valid", bvalid, 1);
      repeat (2) begin
         @(posedge aclk); #1;
         check_eq("b_hold", {bvalid, bresp}, {1'b1, exp_bresp});
      end
      bready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0;
      check_eq("b_drop", bvalid, 0);
      check_eq("aw_ready_after_b", awready, 1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
      int cnt, k;
      for (int i = 0; i <= int'(len); i++) rq.push_back('{d: ed[i], r: er[i], l: (i == int'(len))});
      araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      cnt = 0;
      while (!arready && cnt < 50) begin @(posedge aclk); #1; cnt++; end
      check_eq("ar_wait", cnt < 50, 1);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      check_eq("r_valid_first", rvalid, 1);
      k = 0;
      while (rq.size() != 0 && k < 2000) begin
         rready = (k < rr_len) ? rr_pat[k] : 1'b1;
         @(posedge aclk); #1;
         k++;
      end
      rready = 1'b0;
      check_eq("r_drained", rq.size(), 0);
      if (rr_len == 0) check_eq("r_cycles", k, int'(len) + 1);
      rq.delete();
      check_eq("r_valid_end", rvalid, 0);
      rr_len = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
      repeat (3) @(posedge aclk);
      #1;
      check_eq("rst_awready", awready, 0);
      check_eq("rst_wready", wready, 0);
      check_eq("rst_b", {bvalid, bresp}, 0);
      check_eq("rst_arready", arready, 0);
      check_eq("rst_r", {rvalid, rdata, rresp, rlast}, 0);
      reset = 1'b0;
      repeat (2) begin @(posedge aclk); #1; end
      check_eq("idle_awready", awready, 1);
      check_eq("idle_arready", arready, 1);

      // INCR write/read of words 4..11
      for (int i = 0; i < 8; i++) begin
         wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; ed[i] = 32'hA0 + 32'(i); er[i] = Okay;
      end
      do_write(32'h10, 8'd7, 3'd2, Incr, 7, Okay);
      do_read(32'h10, 8'd7, 3'd2, Incr);

      // WRAP: 0x34, 0x38, 0x3C, 0x30
      for (int i = 0; i < 4; i++) begin
         wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; ed[i] = 32'hB0 + 32'(i); er[i] = Okay;
      end
      do_write(32'h34, 8'd3, 3'd2, Wrap, 3, Okay);
      do_read(32'h34, 8'd3, 3'd2, Wrap);
      ed[0] = 32'hB3; ed[1] = 32'hB0; ed[2] = 32'hB1; ed[3] = 32'hB2;
      do_read(32'h30, 8'd3, 3'd2, Incr);

      // FIXED with partial strobe on the final beat
      wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002; wd[2] = 32'hCCCC_0003; wd[3] = 32'hDDDD_0004;
      ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF; ws[3] = 4'b0011;
      do_write(32'h08, 8'd3, 3'd2, Fixed, 3, Okay);
      ed[0] = 32'hCCCC_0004; er[0] = Okay;
      do_read(32'h08, 8'd0, 3'd2, Fixed);

      // burst running off the top of memory
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hE0 + 32'(i); ws[i] = 4'hF; end
      do_write(32'hF8, 8'd3, 3'd2, Incr, 3, SlvErr);
      ed[0] = 32'hE0; ed[1] = 32'hE1; ed[2] = 0; ed[3] = 0;
      er[0] = Okay; er[1] = Okay; er[2] = SlvErr; er[3] = SlvErr;
      do_read(32'hF8, 8'd3, 3'd2, Incr);

      // early wlast, then reserved burst type
      wd[0] = 32'h51; wd[1] = 32'h52; ws[0] = 4'hF; ws[1] = 4'hF;
      do_write(32'h40, 8'd3, 3'd2, Incr, 1, SlvErr);
      wd[0] = 32'h1234_5678;
      do_write(32'h48, 8'd0, 3'd2, BadBurst, 0, SlvErr);
      ed[0] = 0; er[0] = Okay;
      do_read(32'h48, 8'd0, 3'd2, Incr);

      // beat wider than the bus
      ed[0] = 0; ed[1] = 0; er[0] = SlvErr; er[1] = SlvErr;
      do_read(32'h10, 8'd1, 3'd3, Incr);

      // stalled read stream with a concurrent write elsewhere
      rr_pat[0] = 1; rr_pat[1] = 0; rr_pat[2] = 0; rr_pat[3] = 1;
      rr_pat[4] = 1; rr_pat[5] = 0; rr_pat[6] = 1; rr_len = 7;
      for (int i = 0; i < 4; i++) begin ed[i] = 32'hA0 + 32'(i); er[i] = Okay; end
      wd[0] = 32'h77; wd[1] = 32'h78; ws[0] = 4'hF; ws[1] = 4'hF;
      fork
         do_read(32'h10, 8'd3, 3'd2, Incr);
         do_write(32'h80, 8'd1, 3'd2, Incr, 1, Okay);
      join
      ed[0] = 32'h77; ed[1] = 32'h78; er[0] = Okay; er[1] = Okay;
      do_read(32'h80, 8'd1, 3'd2, Incr);

      // 256-beat bursts exercise the full 8-bit beat counters
      for (int i = 0; i < 256; i++) begin
         wd[i] = 32'(i); ws[i] = 4'hF; ed[i] = 32'hFF; er[i] = Okay;
      end
      do_write(32'hC0, 8'd255, 3'd2, Fixed, 255, Okay);
      do_read(32'hC0, 8'd255, 3'd2, Fixed);

      check_eq("b_queue_empty", bq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
